seq_detect_param: RTL and testbench

Parametrised serial pattern detector, successor to the fixed "101" lab detector. It watches a qualified serial bit stream and compares the most recent PAT_W accepted bits against a pattern that can be reloaded at run time. Overlapping or non-overlapping matching is selected per cycle, and an optional saturating match counter is provided. It sits between a serial source and downstream event logic.

---
 rtl/seq_detect_pkg.sv | 22 ++
 rtl/seq_detect_param_if.sv | 41 ++++
 rtl/seq_detect_param_sat_counter.sv | 35 +++
 rtl/seq_detect_param.sv | 129 ++++++++++++
 tb/tb_seq_detect_param.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_detect_pkg.sv
// -----------------------------------------------------------------------------
// seq_detect_pkg
//   Shared types and default constants for the parametrised serial pattern
//   detector and its helpers.
//   Contents:
//     fill_state_t   - fill FSM states (FILLING, ARMED)
//     PAT_W_DEF      - default pattern length (3)
//     PAT_INIT_DEF   - default pattern after reset (3'b101)
//     CNT_W_DEF      - default match counter width (8)
// -----------------------------------------------------------------------------
package seq_detect_pkg;

    typedef enum logic {
        FILLING = 1'b0,
        ARMED   = 1'b1
    } fill_state_t;

    localparam int         PAT_W_DEF    = 3;
    localparam logic [2:0] PAT_INIT_DEF = 3'b101;
    localparam int         CNT_W_DEF    = 8;

endpackage

// File: rtl/seq_detect_param_if.sv
// -----------------------------------------------------------------------------
// seq_detect_param_if
//   Bundles the serial stream, control and result signals of the pattern
//   detector.
//   Parameters: PAT_W (pattern length), CNT_W (match counter width)
//   Signals:
//     d_in, valid_in   - qualified serial bit
//     overlap          - 1 = overlapping matches allowed
//     pat_load, pat_in - run-time pattern reload
//     cnt_clr          - synchronous clear of match_count
//     found            - one-cycle registered match pulse
//     match_count      - saturating match count
//   Modports: master (stream source / consumer), slave (detector)
// -----------------------------------------------------------------------------
interface seq_detect_param_if
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);

    logic             d_in;
    logic             valid_in;
    logic             overlap;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic             cnt_clr;
    logic             found;
    logic [CNT_W-1:0] match_count;

    modport master (
        output d_in, valid_in, overlap, pat_load, pat_in, cnt_clr,
        input  found, match_count
    );

    modport slave (
        input  d_in, valid_in, overlap, pat_load, pat_in, cnt_clr,
        output found, match_count
    );

endinterface

// File: rtl/seq_detect_param_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Up counter that sticks at its all-ones value. clr wins over inc.
//   Parameter: W (counter width)
//   Ports:
//     clock - rising-edge clock
//     rst_n - asynchronous active-low reset
//     clr   - synchronous clear
//     inc   - increment request
//     count - current count
// -----------------------------------------------------------------------------
module sat_counter
    import seq_detect_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Clear has priority so a simultaneous increment is dropped.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// -----------------------------------------------------------------------------
// seq_detect_param
//   Parametrised serial pattern detector. Compares the most recent PAT_W
//   accepted bits against a run-time reloadable pattern and emits a one-cycle
//   registered pulse on a match. Overlapping or non-overlapping matching is
//   chosen per cycle.
//   Parameters:
//     PAT_W    - pattern length in bits (2..16)
//     PAT_INIT - pattern after reset; bit PAT_W-1 is the first bit received
//     CNT_W    - match counter width
//   Ports:
//     clock - rising-edge clock
//     rst_n - asynchronous active-low reset
//     bus   - seq_detect_param_if.slave (stream, control, found, match_count)
//   Build option:
//     SEQ_DETECT_COUNT_EN - when defined, a saturating match counter with
//                           synchronous clear drives match_count; otherwise
//                           match_count is tied to 0 and cnt_clr is ignored.
// -----------------------------------------------------------------------------
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int               PAT_W    = PAT_W_DEF,
    parameter logic [PAT_W-1:0] PAT_INIT = PAT_INIT_DEF,
    parameter int               CNT_W    = CNT_W_DEF
) (
    input logic               clock,
    input logic               rst_n,
    seq_detect_param_if.slave bus
);

    // fill counts 0..PAT_W, so it needs enough bits to hold PAT_W itself.
    localparam int                FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    fill_state_t       state_q;
    fill_state_t       state_d;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;
    logic [FILL_W-1:0] fill_inc;
    logic [PAT_W-1:0]  hist_q;
    logic [PAT_W-1:0]  hist_d;
    logic [PAT_W-1:0]  pat_q;
    logic [PAT_W-1:0]  pat_d;
    logic [PAT_W-1:0]  shifted;
    logic              match;
    logic              found_d;
    logic              found_q;

    // State register: fill FSM plus the history, fill and pattern datapath.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILLING;
            fill_q  <= '0;
            hist_q  <= '0;
            pat_q   <= PAT_INIT;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            hist_q  <= hist_d;
            pat_q   <= pat_d;
        end
    end

    // Next state. A pattern load wins over an accepted bit and restarts the
    // fill. The match is judged on the post-shift window, so the current bit
    // takes part in the comparison on the edge that accepts it. ARMED simply
    // means the window is full, which is also what stops fill from wrapping.
    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        hist_d   = hist_q;
        pat_d    = pat_q;
        match    = 1'b0;
        shifted  = {hist_q[PAT_W-2:0], bus.d_in};
        fill_inc = (state_q == ARMED) ? fill_q : fill_q + 1'b1;

        if (bus.pat_load) begin
            pat_d  = bus.pat_in;
            fill_d = '0;
        end else if (bus.valid_in) begin
            hist_d = shifted;
            fill_d = fill_inc;
            if ((fill_inc == FILL_FULL) && (shifted == pat_q)) begin
                match = 1'b1;
                // Without overlap the bits of this match must not be reused.
                if (!bus.overlap) begin
                    fill_d = '0;
                end
            end
        end

        state_d = (fill_d == FILL_FULL) ? ARMED : FILLING;
    end

    // Output logic: the pulse is the match of this edge, registered below.
    always_comb begin
        found_d = match;
    end

    // found is a flop so there is no combinational input-to-output path.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            found_q <= 1'b0;
        end else begin
            found_q <= found_d;
        end
    end

    assign bus.found = found_q;

`ifdef SEQ_DETECT_COUNT_EN
    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clock (clock),
        .rst_n (rst_n),
        .clr   (bus.cnt_clr),
        .inc   (match),
        .count (bus.match_count)
    );
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr  = bus.cnt_clr;
    assign bus.match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_param
//   Self-checking bench for seq_detect_param. Two detectors share one stimulus
//   stream: one with an 8-bit counter and one with a 2-bit counter so that
//   counter saturation is reachable. A queue-based reference model predicts
//   found and match_count every cycle; directed sequences add fixed expected
//   pulse positions.
// -----------------------------------------------------------------------------
module tb_seq_detect_param;

    localparam int PW = 3;

`ifdef SEQ_DETECT_COUNT_EN
    localparam bit COUNT_EN = 1'b1;
`else
    localparam bit COUNT_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          rst_n = 1'b0;
    logic          d_in = 1'b0;
    logic          valid_in = 1'b0;
    logic          overlap = 1'b0;
    logic          pat_load = 1'b0;
    logic          cnt_clr = 1'b0;
    logic [PW-1:0] pat_in = '0;

    always #5 clock = ~clock;

    seq_detect_param_if #(.PAT_W(PW), .CNT_W(8)) bus8 ();
    seq_detect_param_if #(.PAT_W(PW), .CNT_W(2)) bus2 ();

    assign bus8.d_in     = d_in;
    assign bus8.valid_in = valid_in;
    assign bus8.overlap  = overlap;
    assign bus8.pat_load = pat_load;
    assign bus8.pat_in   = pat_in;
    assign bus8.cnt_clr  = cnt_clr;
    assign bus2.d_in     = d_in;
    assign bus2.valid_in = valid_in;
    assign bus2.overlap  = overlap;
    assign bus2.pat_load = pat_load;
    assign bus2.pat_in   = pat_in;
    assign bus2.cnt_clr  = cnt_clr;

    seq_detect_param #(.PAT_W(PW), .PAT_INIT(3'b101), .CNT_W(8)) dut8 (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    seq_detect_param #(.PAT_W(PW), .PAT_INIT(3'b101), .CNT_W(2)) dut2 (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    // Reference model: bits accepted since the last restart, oldest first.
    bit            ref_bits[$];
    logic [PW-1:0] ref_pat;
    int            ref_cnt8;
    int            ref_cnt2;
    bit            ref_found;

    int n_checks = 0;
    int n_fail   = 0;
    bit prev_found = 1'b0;
    int consec = 0;

    int stream_bits[15] = '{0, 1, 0, 1, 1, 0, 1, 0, 0, 0, 1, 0, 1, 0, 1};

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic bit modelMatch();
        if (ref_bits.size() != PW) return 1'b0;
        for (int i = 0; i < PW; i++) begin
            if (ref_bits[i] != ref_pat[PW-1-i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic modelEdge(input bit d, input bit v, input bit ov, input bit ld,
                             input logic [PW-1:0] pin, input bit clr);
        bit m;
        m = 1'b0;
        ref_found = 1'b0;
        if (ld) begin
            ref_pat = pin;
            ref_bits.delete();
        end else if (v) begin
            ref_bits.push_back(d);
            if (ref_bits.size() > PW) void'(ref_bits.pop_front());
            m = modelMatch();
            if (m) begin
                ref_found = 1'b1;
                if (!ov) ref_bits.delete();
            end
        end
        if (clr) begin
            ref_cnt8 = 0;
            ref_cnt2 = 0;
        end else if (m) begin
            if (ref_cnt8 < 255) ref_cnt8++;
            if (ref_cnt2 < 3) ref_cnt2++;
        end
    endtask

    task automatic modelReset();
        ref_bits.delete();
        ref_pat   = 3'b101;
        ref_cnt8  = 0;
        ref_cnt2  = 0;
        ref_found = 1'b0;
    endtask

    // Drive one cycle, advance the model on the edge, check just after it.
    task automatic applyStimulus(input bit d, input bit v, input bit ov, input bit ld,
                                 input logic [PW-1:0] pin, input bit clr);
        d_in     = d;
        valid_in = v;
        overlap  = ov;
        pat_load = ld;
        pat_in   = pin;
        cnt_clr  = clr;
        @(posedge clock);
        modelEdge(d, v, ov, ld, pin, clr);
        #1;
        checkOutput("found", bus8.found, ref_found);
        checkOutput("found_c2", bus2.found, ref_found);
        checkOutput("count", bus8.match_count, COUNT_EN ? ref_cnt8 : 0);
        checkOutput("count_c2", bus2.match_count, COUNT_EN ? ref_cnt2 : 0);
        if (bus8.found && prev_found) consec++;
        prev_found = bus8.found;
    endtask

    task automatic sendBit(input bit d, input bit ov);
        applyStimulus(d, 1'b1, ov, 1'b0, '0, 1'b0);
    endtask

    // Asserts reset between edges so the asynchronous path is exercised.
    task automatic doReset();
        valid_in = 1'b0;
        pat_load = 1'b0;
        cnt_clr  = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_found", bus8.found, 0);
        checkOutput("rst_count", bus8.match_count, 0);
        checkOutput("rst_count_c2", bus2.match_count, 0);
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        prev_found = 1'b0;
    endtask

    task automatic runStream(input bit ov, input int gaps, output logic [14:0] mask);
        mask = '0;
        for (int i = 0; i < 15; i++) begin
            sendBit(stream_bits[i][0], ov);
            mask[i] = bus8.found;
            for (int g = 0; g < gaps; g++) begin
                applyStimulus(1'b0, 1'b0, ov, 1'b0, '0, 1'b0);
            end
        end
    endtask

    initial begin
        logic [14:0] mask;
        int          pulses;
        int          sat_exp[5] = '{1, 2, 3, 3, 3};
        int          k;

        modelReset();
        $display("[TB] start");

        // Overlapping matching on the reference stream.
        doReset();
        runStream(1'b1, 0, mask);
        checkOutput("ovl_mask", mask, 15'h5048);
        checkOutput("ovl_count", bus8.match_count, COUNT_EN ? 4 : 0);

        // Non-overlapping matching on the same stream.
        doReset();
        runStream(1'b0, 0, mask);
        checkOutput("novl_mask", mask, 15'h1048);
        checkOutput("novl_count", bus8.match_count, COUNT_EN ? 3 : 0);

        // Gaps in valid_in must be transparent.
        doReset();
        consec = 0;
        runStream(1'b1, 2, mask);
        checkOutput("gap_mask", mask, 15'h5048);
        checkOutput("gap_no_double", consec, 0);

        // Pattern reload discards the concurrent bit and restarts the fill.
        doReset();
        sendBit(1'b1, 1'b1);
        sendBit(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 3'b110, 1'b0);
        checkOutput("load_no_found", bus8.found, 0);
        pulses = 0;
        sendBit(1'b1, 1'b1);
        pulses += int'(bus8.found);
        sendBit(1'b1, 1'b1);
        pulses += int'(bus8.found);
        sendBit(1'b0, 1'b1);
        pulses += int'(bus8.found);
        checkOutput("load_pulses", pulses, 1);

        // Counter saturation on the 2-bit instance, then clear against a match.
        doReset();
        k = 0;
        for (int i = 0; i < 11; i++) begin
            sendBit(bit'(~i[0]), 1'b1);
            if (i >= 2 && i[0] == 1'b0) begin
                checkOutput($sformatf("sat_count%0d", k), bus2.match_count,
                            COUNT_EN ? sat_exp[k] : 0);
                k++;
            end
        end
        sendBit(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1);
        checkOutput("clr_found", bus2.found, 1);
        checkOutput("clr_count", bus2.match_count, 0);

        // Asynchronous reset mid-stream discards partial history.
        doReset();
        sendBit(1'b1, 1'b1);
        sendBit(1'b0, 1'b1);
        sendBit(1'b1, 1'b1);
        sendBit(1'b1, 1'b1);
        sendBit(1'b0, 1'b1);
        doReset();
        sendBit(1'b1, 1'b1);
        checkOutput("rst_partial", bus8.found, 0);
        sendBit(1'b1, 1'b1);
        sendBit(1'b0, 1'b1);
        sendBit(1'b1, 1'b1);
        checkOutput("rst_fresh", bus8.found, 1);

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(bit'($urandom_range(0, 1)),
                          $urandom_range(0, 3) != 0,
                          bit'($urandom_range(0, 1)),
                          $urandom_range(0, 19) == 0,
                          PW'($urandom_range(0, 7)),
                          $urandom_range(0, 29) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
